// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO and its pointer delay chain.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

  // Widest pointer the Gray helper handles; callers cast down to their own width.
  localparam int MAX_PTR_WIDTH = 32;

  // Binary to reflected Gray code. Truncating the result to N bits gives the
  // same value as converting an N-bit pointer directly, since the input is zero-extended.
  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake bundle of the synchronous FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_wr_en;
  logic                  o_Full_Flag;
  logic                  i_rd_en;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_Empty_Flag;

  // Producer/consumer side that drives requests into the FIFO.
  modport master (
    output i_wr_data, i_wr_en, i_rd_en,
    input  o_Full_Flag, o_rd_data, o_Empty_Flag
  );

  // The FIFO itself.
  modport slave (
    input  i_wr_data, i_wr_en, i_rd_en,
    output o_Full_Flag, o_rd_data, o_Empty_Flag
  );

endinterface

// File: rtl/fifo_ptr_delay.sv
// Register chain that delays a Gray pointer before the opposite side compares against it.
module fifo_ptr_delay #(
  parameter int WIDTH      = 6,
  parameter int NUM_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] src;
      logic [WIDTH-1:0] q_reg;

      if (gi == 0) begin : g_first
        assign src = d;
      end else begin : g_next
        assign src = g_stage[gi-1].q_reg;
      end

      // One pipeline stage, cleared immediately by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else begin
          q_reg <= src;
        end
      end
    end
  endgenerate

  assign q = g_stage[NUM_STAGES-1].q_reg;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with Gray pointers and delayed (conservative) full/empty flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH               = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH               = DEFAULT_ADDR_WIDTH,
  parameter int ADDR_WIDTH_PLUS_OVERFLOW = DEFAULT_ADDR_WIDTH + 1,
  parameter int DEPTH                    = DEFAULT_DEPTH,
  parameter int NUM_STAGES               = 2
) (
  input  logic       i_clk,
  input  logic       i_RST,
  sync_fifo_if.slave bus
);

  localparam int PW = ADDR_WIDTH_PLUS_OVERFLOW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         wr_gray_reg;
  logic [PW-1:0]         rd_gray_reg;
  logic [PW-1:0]         wr_ptr_next;
  logic [PW-1:0]         rd_ptr_next;
  logic [PW-1:0]         wr_ptr_seen;
  logic [PW-1:0]         rd_ptr_seen;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  full_flag;
  logic                  empty_flag;
  logic                  wr_accept;
  logic                  rd_accept;

  assign wr_accept   = bus.i_wr_en && !full_flag;
  assign rd_accept   = bus.i_rd_en && !empty_flag;
  assign wr_ptr_next = wr_ptr_reg + PW'(1);
  assign rd_ptr_next = rd_ptr_reg + PW'(1);

  // Empty compares our own Gray read pointer against the delayed write pointer;
  // full compares the Gray write pointer against the delayed read pointer with
  // its top two bits inverted (Gray equivalent of "one full lap ahead").
  assign empty_flag = (rd_gray_reg == wr_ptr_seen);
  assign full_flag  = (wr_gray_reg == {~rd_ptr_seen[PW-1:PW-2], rd_ptr_seen[PW-3:0]});

  assign bus.o_Empty_Flag = empty_flag;
  assign bus.o_Full_Flag  = full_flag;
  assign bus.o_rd_data    = rd_data_reg;

  // Storage array: write port only, no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= bus.i_wr_data;
    end
  end

  // Write pointer; the Gray copy is loaded from the next value so it moves on the same edge.
  always_ff @(posedge i_clk or negedge i_RST) begin
    if (!i_RST) begin
      wr_ptr_reg  <= '0;
      wr_gray_reg <= '0;
    end else if (wr_accept) begin
      wr_ptr_reg  <= wr_ptr_next;
      wr_gray_reg <= PW'(bin2gray(MAX_PTR_WIDTH'(wr_ptr_next)));
    end
  end

  // Read pointer and registered read data; an empty read returns zero.
  always_ff @(posedge i_clk or negedge i_RST) begin
    if (!i_RST) begin
      rd_ptr_reg  <= '0;
      rd_gray_reg <= '0;
      rd_data_reg <= '0;
    end else if (rd_accept) begin
      rd_ptr_reg  <= rd_ptr_next;
      rd_gray_reg <= PW'(bin2gray(MAX_PTR_WIDTH'(rd_ptr_next)));
      rd_data_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
    end else if (bus.i_rd_en) begin
      rd_data_reg <= '0;
    end
  end

  fifo_ptr_delay #(
    .WIDTH      (PW),
    .NUM_STAGES (NUM_STAGES)
  ) u_wr_delay (
    .clk   (i_clk),
    .rst_n (i_RST),
    .d     (wr_gray_reg),
    .q     (wr_ptr_seen)
  );

  fifo_ptr_delay #(
    .WIDTH      (PW),
    .NUM_STAGES (NUM_STAGES)
  ) u_rd_delay (
    .clk   (i_clk),
    .rst_n (i_RST),
    .d     (rd_gray_reg),
    .q     (rd_ptr_seen)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (defaults: 8-bit data, 32 words, 2 delay stages).
module tb_sync_fifo;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sync_fifo_if #(.DATA_WIDTH(8)) bus ();

  sync_fifo #(
    .DATA_WIDTH               (8),
    .ADDR_WIDTH               (5),
    .ADDR_WIDTH_PLUS_OVERFLOW (6),
    .DEPTH                    (32),
    .NUM_STAGES               (2)
  ) dut (
    .i_clk (clk),
    .i_RST (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    bus.i_wr_data = 8'h00;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.o_Empty_Flag); end
    n_checks++;
    if (bus.o_Full_Flag !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.o_Full_Flag); end
    n_checks++;
    if (bus.o_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", bus.o_rd_data); end
    $display("test_reset: empty=%b full=%b rd_data=%h", bus.o_Empty_Flag, bus.o_Full_Flag, bus.o_rd_data);
  endtask

  task automatic test_basic();
    bus.i_wr_en = 1'b1;
    bus.i_wr_data = 8'd1;
    step();
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b1) begin n_fail++; $display("FAIL basic_empty_edge1: got %b expected 1", bus.o_Empty_Flag); end
    bus.i_wr_data = 8'd2;
    step();
    bus.i_wr_en = 1'b0;
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b1) begin n_fail++; $display("FAIL basic_empty_edge2: got %b expected 1", bus.o_Empty_Flag); end
    step();
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b0) begin n_fail++; $display("FAIL basic_empty_edge3: got %b expected 0", bus.o_Empty_Flag); end
    step();
    step();
    bus.i_rd_en = 1'b1;
    step();
    n_checks++;
    if (bus.o_rd_data !== 8'd1) begin n_fail++; $display("FAIL basic_read1: got %h expected 01", bus.o_rd_data); end
    step();
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'd2) begin n_fail++; $display("FAIL basic_read2: got %h expected 02", bus.o_rd_data); end
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after: got %b expected 1", bus.o_Empty_Flag); end
    step();
    n_checks++;
    if (bus.o_rd_data !== 8'd2) begin n_fail++; $display("FAIL basic_hold: got %h expected 02", bus.o_rd_data); end
    $display("test_basic: last rd_data=%h empty=%b", bus.o_rd_data, bus.o_Empty_Flag);
  endtask

  task automatic test_read_empty();
    bus.i_rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (bus.o_rd_data !== 8'h00) begin n_fail++; $display("FAIL empty_read_data%0d: got %h expected 00", i, bus.o_rd_data); end
      n_checks++;
      if (bus.o_Empty_Flag !== 1'b1 || bus.o_Full_Flag !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_read_flags%0d: got empty=%b full=%b expected empty=1 full=0", i, bus.o_Empty_Flag, bus.o_Full_Flag);
      end
      $display("test_read_empty: cycle %0d rd_data=%h", i, bus.o_rd_data);
    end
    bus.i_rd_en = 1'b0;
  endtask

  task automatic test_full();
    bus.i_wr_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      bus.i_wr_data = 8'(i);
      step();
      if (i == 31) begin
        n_checks++;
        if (bus.o_Full_Flag !== 1'b0) begin n_fail++; $display("FAIL full_after31: got %b expected 0", bus.o_Full_Flag); end
      end
    end
    bus.i_wr_en = 1'b0;
    n_checks++;
    if (bus.o_Full_Flag !== 1'b1) begin n_fail++; $display("FAIL full_after32: got %b expected 1", bus.o_Full_Flag); end
    step();
    step();
    step();
    n_checks++;
    if (bus.o_Full_Flag !== 1'b1 || bus.o_Empty_Flag !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flags: got full=%b empty=%b expected full=1 empty=0", bus.o_Full_Flag, bus.o_Empty_Flag);
    end
    bus.i_wr_en = 1'b1;
    bus.i_wr_data = 8'hFF;
    step();
    bus.i_wr_en = 1'b0;
    n_checks++;
    if (bus.o_Full_Flag !== 1'b1) begin n_fail++; $display("FAIL full_overwrite: got full=%b expected 1", bus.o_Full_Flag); end
    $display("test_full: full=%b empty=%b", bus.o_Full_Flag, bus.o_Empty_Flag);
  endtask

  task automatic test_drain();
    bus.i_rd_en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      n_checks++;
      if (bus.o_rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data%0d: got %h expected %h", i, bus.o_rd_data, 8'(i)); end
      if (i == 2) begin
        n_checks++;
        if (bus.o_Full_Flag !== 1'b1) begin n_fail++; $display("FAIL drain_full_lag: got %b expected 1", bus.o_Full_Flag); end
      end
      if (i == 3) begin
        n_checks++;
        if (bus.o_Full_Flag !== 1'b0) begin n_fail++; $display("FAIL drain_full_fall: got %b expected 0", bus.o_Full_Flag); end
      end
      if (i == 31) begin
        n_checks++;
        if (bus.o_Empty_Flag !== 1'b0) begin n_fail++; $display("FAIL drain_empty31: got %b expected 0", bus.o_Empty_Flag); end
      end
    end
    $display("test_drain: last rd_data=%h", bus.o_rd_data);
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b1 || bus.o_Full_Flag !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_flags: got empty=%b full=%b expected empty=1 full=0", bus.o_Empty_Flag, bus.o_Full_Flag);
    end
    step();
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'h00) begin n_fail++; $display("FAIL drain_extra_read: got %h expected 00", bus.o_rd_data); end
    $display("test_drain: extra read rd_data=%h", bus.o_rd_data);
  endtask

  task automatic test_back_to_back();
    bus.i_wr_en = 1'b1;
    bus.i_wr_data = 8'h11;
    step();
    bus.i_wr_en = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_pre: got %b expected 0", bus.o_Empty_Flag); end
    bus.i_wr_en = 1'b1;
    bus.i_rd_en = 1'b1;
    bus.i_wr_data = 8'h22;
    step();
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'h11) begin n_fail++; $display("FAIL b2b_read: got %h expected 11", bus.o_rd_data); end
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b1) begin n_fail++; $display("FAIL b2b_empty_lag: got %b expected 1", bus.o_Empty_Flag); end
    step();
    step();
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_fall: got %b expected 0", bus.o_Empty_Flag); end
    bus.i_rd_en = 1'b1;
    step();
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'h22 || bus.o_Empty_Flag !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got data=%h empty=%b expected data=22 empty=1", bus.o_rd_data, bus.o_Empty_Flag);
    end
    $display("test_back_to_back: rd_data=%h empty=%b", bus.o_rd_data, bus.o_Empty_Flag);
  endtask

  task automatic test_reset_mid();
    bus.i_wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.i_wr_data = 8'(8'hA0 + i);
      step();
    end
    bus.i_wr_en = 1'b0;
    step();
    step();
    step();
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b0) begin n_fail++; $display("FAIL mid_empty_pre: got %b expected 0", bus.o_Empty_Flag); end
    bus.i_rd_en = 1'b1;
    step();
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'hA0) begin n_fail++; $display("FAIL mid_read_pre: got %h expected a0", bus.o_rd_data); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_Empty_Flag !== 1'b1 || bus.o_Full_Flag !== 1'b0 || bus.o_rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: got empty=%b full=%b data=%h expected empty=1 full=0 data=00",
               bus.o_Empty_Flag, bus.o_Full_Flag, bus.o_rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.i_rd_en = 1'b1;
    step();
    bus.i_rd_en = 1'b0;
    n_checks++;
    if (bus.o_rd_data !== 8'h00 || bus.o_Empty_Flag !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_read_post: got data=%h empty=%b expected data=00 empty=1", bus.o_rd_data, bus.o_Empty_Flag);
    end
    $display("test_reset_mid: post-reset rd_data=%h empty=%b", bus.o_rd_data, bus.o_Empty_Flag);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_read_empty();
    test_full();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
